ahb_mem_arbiter: RTL



---
 rtl/ahb_mem_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ahb_mem_arbiter.sv
// Two-master AHB-Lite arbiter: core instruction port (m0) and data port (m1) share one memory slave.
// Define ARB_RR_EN for round-robin on contention; otherwise m1 has fixed priority.
module ahb_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [2:0]        m0_hburst,
    input  logic              m0_hmastlock,
    input  logic [3:0]        m0_hprot,
    input  logic [1:0]        m0_htrans,
    input  logic [DATA_W-1:0] m0_hwdata,
    output logic [DATA_W-1:0] m0_hrdata,
    output logic              m0_hready,
    output logic              m0_hresp,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [2:0]        m1_hburst,
    input  logic              m1_hmastlock,
    input  logic [3:0]        m1_hprot,
    input  logic [1:0]        m1_htrans,
    input  logic [DATA_W-1:0] m1_hwdata,
    output logic [DATA_W-1:0] m1_hrdata,
    output logic              m1_hready,
    output logic              m1_hresp,
    output logic [ADDR_W-1:0] s_haddr,
    output logic              s_hwrite,
    output logic [2:0]        s_hsize,
    output logic [2:0]        s_hburst,
    output logic              s_hmastlock,
    output logic [3:0]        s_hprot,
    output logic [1:0]        s_htrans,
    output logic [DATA_W-1:0] s_hwdata,
    input  logic [DATA_W-1:0] s_hrdata,
    input  logic              s_hready,
    input  logic              s_hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [2:0]        size;
        logic [3:0]        prot;
    } req_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

    owner_e     owner_q, owner_d;
    logic [1:0] pend_v_q, pend_v_d;
    req_t       pend0_q, pend0_d, pend1_q, pend1_d;
    req_t       hold_q, hold_d;
`ifdef ARB_RR_EN
    logic       last_q, last_d;     // 1: m1 was granted last
`endif

    req_t       live0, live1, win_req;
    logic       m0_rdy, m1_rdy;
    logic [1:0] live, req, gnt;

    // Burst and lock are not forwarded: every transfer is issued as a SINGLE.
    logic unused_ok;
    assign unused_ok = ^{m0_hburst, m0_hmastlock, m1_hburst, m1_hmastlock};

    assign live0 = '{addr: m0_haddr, write: m0_hwrite, size: m0_hsize, prot: m0_hprot};
    assign live1 = '{addr: m1_haddr, write: m1_hwrite, size: m1_hsize, prot: m1_hprot};

    assign m0_rdy = (owner_q == OWN_M0) ? s_hready : !pend_v_q[0];
    assign m1_rdy = (owner_q == OWN_M1) ? s_hready : !pend_v_q[1];

    assign live = {m1_htrans[1] & m1_rdy, m0_htrans[1] & m0_rdy};
    assign req  = pend_v_q | live;

    always_comb begin
        gnt = 2'b00;
        if (s_hready) begin
            if (req[0] && req[1]) begin
`ifdef ARB_RR_EN
                gnt = last_q ? 2'b01 : 2'b10;
`else
                gnt = 2'b10;
`endif
            end else begin
                gnt = req;
            end
        end
    end

    always_comb begin
        win_req = hold_q;
        if (gnt[1])
            win_req = pend_v_q[1] ? pend1_q : live1;
        else if (gnt[0])
            win_req = pend_v_q[0] ? pend0_q : live0;
    end

    // Address path is combinational so an uncontested request reaches the slave in the same cycle.
    assign s_haddr     = win_req.addr;
    assign s_hwrite    = win_req.write;
    assign s_hsize     = win_req.size;
    assign s_hprot     = win_req.prot;
    assign s_htrans    = (|gnt) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s_hburst    = 3'b000;
    assign s_hmastlock = 1'b0;

    assign s_hwdata  = (owner_q == OWN_M1) ? m1_hwdata : m0_hwdata;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;
    assign m0_hready = m0_rdy;
    assign m1_hready = m1_rdy;
    assign m0_hresp  = (owner_q == OWN_M0) ? s_hresp : 1'b0;
    assign m1_hresp  = (owner_q == OWN_M1) ? s_hresp : 1'b0;

    always_comb begin
        pend_v_d = pend_v_q;
        pend0_d  = pend0_q;
        pend1_d  = pend1_q;
        // An accepted live request that lost (or saw a slave wait state) is parked until granted.
        if (gnt[0])       pend_v_d[0] = 1'b0;
        else if (live[0]) begin
            pend_v_d[0] = 1'b1;
            pend0_d     = live0;
        end
        if (gnt[1])       pend_v_d[1] = 1'b0;
        else if (live[1]) begin
            pend_v_d[1] = 1'b1;
            pend1_d     = live1;
        end
        hold_d  = (|gnt) ? win_req : hold_q;
        owner_d = owner_q;
        if (s_hready)
            owner_d = gnt[1] ? OWN_M1 : (gnt[0] ? OWN_M0 : OWN_NONE);
`ifdef ARB_RR_EN
        last_d = gnt[1] ? 1'b1 : (gnt[0] ? 1'b0 : last_q);
`endif
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            owner_q  <= OWN_NONE;
            pend_v_q <= 2'b00;
            pend0_q  <= '0;
            pend1_q  <= '0;
            hold_q   <= '0;
`ifdef ARB_RR_EN
            last_q   <= 1'b0;
`endif
        end else begin
            owner_q  <= owner_d;
            pend_v_q <= pend_v_d;
            pend0_q  <= pend0_d;
            pend1_q  <= pend1_d;
            hold_q   <= hold_d;
`ifdef ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

endmodule
